muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (even, >=8).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request to launch the operation selected by funct.
REQ-005 SHALL have port: funct  input  6  R-type funct: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x12 mflo.
REQ-006 SHALL have port: src_a  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port: src_b  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port: busy  output  1  high while an operation is in flight (pipeline stall).
REQ-009 SHALL have port: done  output  1  one-cycle pulse when hi/lo are updated.
REQ-010 SHALL have ports: hi, lo  output  WIDTH  committed HI/LO registers.
REQ-011 SHALL have port: result  output  WIDTH  hi when funct=mfhi, lo when funct=mflo, else 0 (combinational).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; busy = (state != IDLE).
REQ-013 SHALL accept start only in IDLE with funct in {0x18..0x1B}; other funct codes or start in RUN/DONE are ignored with no state change.
REQ-014 On accept at edge N, SHALL latch operands and signedness, enter RUN; busy high from N+1.
REQ-015 SHALL iterate one bit per cycle for exactly WIDTH cycles in RUN (shift-add multiply, restoring divide on magnitudes).
REQ-016 SHALL enter DONE at edge N+WIDTH+1, updating hi/lo at that edge, with done=1 and busy=1 for that cycle only; IDLE at N+WIDTH+2.
REQ-017 Multiply SHALL produce the full 2*WIDTH product: hi = upper half, lo = lower half; signed for mult, unsigned for multu.
REQ-018 Divide SHALL give lo = quotient truncated toward zero, hi = remainder with sign of the dividend.
REQ-019 Divide by zero SHALL take the same latency and give lo = all ones, hi = src_a.
REQ-020 Signed most-negative / -1 SHALL give lo = most-negative value, hi = 0.
REQ-021 hi/lo SHALL hold their old values until DONE; result reflects committed hi/lo only.
REQ-022 Changes on src_a/src_b/funct after accept SHALL NOT affect the in-flight operation.

Reset
REQ-023 rstn low SHALL asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear all iteration registers.
REQ-024 Reset during RUN/DONE SHALL abort the operation with no hi/lo update; first accept is possible on the first edge after rstn rises.

Structure
REQ-025 Funct codes and state encodings SHALL live in the shared processor definitions package, reused by the decoder and hazard unit.
REQ-026 One sub-module is natural: muldiv_step (one combinational shift-add/shift-subtract iteration, parametrised by WIDTH); sign fix-up and FSM remain in muldiv_unit.

Verification (WIDTH=32)
REQ-027 mult 0x00000007 x 0xFFFFFFFD -> done at N+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high N+1..N+33.
REQ-028 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 div 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 divu 0x00000064 / 0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 cycles.
REQ-031 Second start with new operands at N+5 while busy -> ignored; first result unchanged; mflo during busy returns the previous lo.
REQ-032 rstn pulsed low at N+10 of a mult -> busy=0, done never pulses, hi=lo=0; a new mult launched next cycle completes correctly.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared processor definitions for the multiply/divide unit: funct codes,
// FSM state encoding and the latched per-operation control word.
package muldiv_unit_pkg;

  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Control captured at accept time so later funct/operand changes cannot leak in
  typedef struct packed {
    logic is_div;
    logic neg_q;     // negate product (mult) or quotient (div)
    logic neg_r;     // negate remainder (follows dividend sign)
    logic div_zero;  // divisor was zero
  } muldiv_ctl_t;

  // mult/multu/div/divu occupy 0x18..0x1B
  function automatic logic is_muldiv_op(input logic [FUNCT_W-1:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  // Even codes in the group are the signed variants
  function automatic logic is_signed_op(input logic [FUNCT_W-1:0] f);
    return ~f[0];
  endfunction

  function automatic logic is_div_op(input logic [FUNCT_W-1:0] f);
    return f[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Multiply: acc holds the running upper half, qr the multiplier/lower half.
// Divide:   acc holds the partial remainder, qr the dividend/quotient.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] qr,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] qr_n
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Compute both iteration flavours and select by operation
  always_comb begin
    sum    = {1'b0, acc} + (qr[0] ? {1'b0, opb} : (WIDTH+1)'(0));
    rem_sh = {acc, qr[WIDTH-1]};
    ge     = rem_sh >= {1'b0, opb};
    // True difference is below 2^WIDTH whenever ge holds, so the low bits suffice
    diff   = rem_sh[WIDTH-1:0] - opb;

    if (is_div) begin
      acc_n = ge ? diff : rem_sh[WIDTH-1:0];
      qr_n  = {qr[WIDTH-2:0], ge};
    end else begin
      acc_n = sum[WIDTH:1];
      qr_n  = {sum[0], qr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with committed HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then applies sign fix-up on the
// commit edge into DONE.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  muldiv_state_e    state, state_next;
  muldiv_ctl_t      ctl;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, qr, opb, a_raw;
  logic [WIDTH-1:0] acc_n, qr_n;

  logic             accept_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic             iter_last_c;

  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quo_c, rem_c;
  logic [WIDTH-1:0]   hi_fix_c, lo_fix_c;

  // Operand magnitudes and accept decode
  always_comb begin
    accept_c = start && (state == ST_IDLE) && is_muldiv_op(funct);
    a_neg_c  = is_signed_op(funct) && src_a[WIDTH-1];
    b_neg_c  = is_signed_op(funct) && src_b[WIDTH-1];
    a_mag_c  = a_neg_c ? -src_a : src_a;
    b_mag_c  = b_neg_c ? -src_b : src_b;
    iter_last_c = (cnt == CNT_W'(WIDTH));
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept_c) state_next = ST_RUN;
      ST_RUN:  if (iter_last_c) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      done  <= (state_next == ST_DONE);
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (ctl.is_div),
    .acc    (acc),
    .qr     (qr),
    .opb    (opb),
    .acc_n  (acc_n),
    .qr_n   (qr_n)
  );

  // Sign fix-up and divide-by-zero override applied at commit
  always_comb begin
    prod_c = {acc, qr};
    if (ctl.neg_q) prod_c = -prod_c;
    quo_c  = ctl.neg_q ? -qr : qr;
    rem_c  = ctl.neg_r ? -acc : acc;
    if (!ctl.is_div) begin
      hi_fix_c = prod_c[2*WIDTH-1:WIDTH];
      lo_fix_c = prod_c[WIDTH-1:0];
    end else if (ctl.div_zero) begin
      hi_fix_c = a_raw;
      lo_fix_c = '1;
    end else begin
      hi_fix_c = rem_c;
      lo_fix_c = quo_c;
    end
  end

  // Operand latch, iteration registers and HI/LO commit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctl   <= '0;
      cnt   <= '0;
      acc   <= '0;
      qr    <= '0;
      opb   <= '0;
      a_raw <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept_c) begin
      ctl.is_div   <= is_div_op(funct);
      ctl.neg_q    <= a_neg_c ^ b_neg_c;
      ctl.neg_r    <= a_neg_c;
      ctl.div_zero <= is_div_op(funct) && (src_b == '0);
      cnt   <= '0;
      acc   <= '0;
      a_raw <= src_a;
      if (is_div_op(funct)) begin
        qr  <= a_mag_c;
        opb <= b_mag_c;
      end else begin
        qr  <= b_mag_c;
        opb <= a_mag_c;
      end
    end else if (state == ST_RUN) begin
      if (iter_last_c) begin
        hi <= hi_fix_c;
        lo <= lo_fix_c;
      end else begin
        acc <= acc_n;
        qr  <= qr_n;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Move-from-HI/LO read port
  always_comb begin
    result = '0;
    if (funct == FUNCT_MFHI)      result = hi;
    else if (funct == FUNCT_MFLO) result = lo;
  end

endmodule
